// File: rtl/audio_axi_sample_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_axi_sample_pkg
// Description : Register map, status/control bit positions and response codes
//               shared by the audio sample register block.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_axi_sample_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_SAMPLE = 4'h8;
    localparam logic [3:0] ADDR_DIV    = 4'hC;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_FLUSH_BIT      = 1;

    localparam int STAT_EMPTY_BIT      = 16;
    localparam int STAT_FULL_BIT       = 17;
    localparam int STAT_UNDERRUN_BIT   = 18;
    localparam int STAT_OVERFLOW_BIT   = 19;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage
`default_nettype wire

// File: rtl/audio_axi_sample_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_axi_sample_regs_if
// Description : AXI4-Lite bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_axi_sample_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_fifo
// Description : Synchronous sample FIFO with flush; a push in the flush cycle
//               survives as the single remaining entry.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int AW = 4,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = level[AW];
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (flush || !full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(do_push);
            level  <= (AW+1)'(do_push);
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? '0 : wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_axi_sample_regs.sv
`default_nettype none
// ============================================================================
// Module      : audio_axi_sample_regs
// Description : AXI4-Lite register block feeding a sample FIFO that is drained
//               one entry per divider tick onto a streaming output.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_axi_sample_regs
    import audio_axi_sample_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_AW            = 4,
    parameter int SAMPLE_W           = 16,
    parameter int DIV_RESET          = 2267
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    audio_axi_sample_regs_if.slave  s_axi,
    output logic [SAMPLE_W-1:0]     sample_out,
    output logic                    sample_valid
);

    localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

    logic                          awready, wready, bvalid, arready, rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata, rd_mux, status_word;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_raw, rd_addr_raw;
    logic [3:0]                    wr_addr, rd_addr;
    logic                          wr_start, wr_en, ar_start, rd_en;
    logic                          enable, underrun, overflow;
    logic [15:0]                   div, tick_cnt;
    logic [SAMPLE_W-1:0]           last_sample, fifo_dout;
    logic                          tick, flush, push, pop, fifo_full, fifo_empty;
    logic [FIFO_AW:0]              fifo_level;
    logic                          status_w1c, unused_inputs;

    assign wr_addr_raw = s_axi.S_AXI_AWADDR;
    assign rd_addr_raw = s_axi.S_AXI_ARADDR;
    assign wr_addr     = {wr_addr_raw[3:2], 2'b00};
    assign rd_addr     = {rd_addr_raw[3:2], 2'b00};

    // Ready is a registered pulse; the write lands on the edge where it meets VALID.
    assign wr_start = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid && !awready;
    assign wr_en    = awready && wready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign ar_start = s_axi.S_AXI_ARVALID && !rvalid && !arready;
    assign rd_en    = arready && s_axi.S_AXI_ARVALID;

    assign flush      = wr_en && (wr_addr == ADDR_CTRL) && s_axi.S_AXI_WSTRB[0]
                        && s_axi.S_AXI_WDATA[CTRL_FLUSH_BIT];
    assign push       = wr_en && (wr_addr == ADDR_SAMPLE);
    assign status_w1c = wr_en && (wr_addr == ADDR_STATUS) && s_axi.S_AXI_WSTRB[2];
    assign tick       = enable && (tick_cnt == 16'd0);
    assign pop        = tick && !fifo_empty && !flush;

    always_comb begin
        status_word                    = '0;
        status_word[FIFO_AW:0]         = fifo_level;
        status_word[STAT_EMPTY_BIT]    = fifo_empty;
        status_word[STAT_FULL_BIT]     = fifo_full;
        status_word[STAT_UNDERRUN_BIT] = underrun;
        status_word[STAT_OVERFLOW_BIT] = overflow;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_CTRL:   rd_mux[CTRL_ENABLE_BIT] = enable;
            ADDR_STATUS: rd_mux = status_word;
            ADDR_SAMPLE: rd_mux[SAMPLE_W-1:0] = last_sample;
            ADDR_DIV:    rd_mux[15:0] = div;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            arready      <= 1'b0;
            rvalid       <= 1'b0;
            rdata        <= '0;
            enable       <= 1'b0;
            div          <= DIV_INIT;
            tick_cnt     <= DIV_INIT;
            last_sample  <= '0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            awready <= wr_start;
            wready  <= wr_start;
            arready <= ar_start;

            if (wr_en) begin
                bvalid <= 1'b1;
            end else if (s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end

            if (rd_en) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (s_axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end

            if (wr_en && (wr_addr == ADDR_CTRL) && s_axi.S_AXI_WSTRB[0]) begin
                enable <= s_axi.S_AXI_WDATA[CTRL_ENABLE_BIT];
            end
            if (wr_en && (wr_addr == ADDR_DIV)) begin
                if (s_axi.S_AXI_WSTRB[0]) div[7:0]  <= s_axi.S_AXI_WDATA[7:0];
                if (s_axi.S_AXI_WSTRB[1]) div[15:8] <= s_axi.S_AXI_WDATA[15:8];
            end
            if (push) begin
                last_sample <= s_axi.S_AXI_WDATA[SAMPLE_W-1:0];
            end

            // Setting has priority over a same-cycle W1C clear.
            if (tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (status_w1c && s_axi.S_AXI_WDATA[STAT_UNDERRUN_BIT]) begin
                underrun <= 1'b0;
            end
            if (push && fifo_full && !pop && !flush) begin
                overflow <= 1'b1;
            end else if (status_w1c && s_axi.S_AXI_WDATA[STAT_OVERFLOW_BIT]) begin
                overflow <= 1'b0;
            end

            if (!enable || tick) begin
                tick_cnt <= div;
            end else begin
                tick_cnt <= tick_cnt - 16'd1;
            end

            sample_valid <= pop;
            if (pop) begin
                sample_out <= fifo_dout;
            end
        end
    end

    audio_sample_fifo #(
        .AW (FIFO_AW),
        .W  (SAMPLE_W)
    ) u_fifo (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (s_axi.S_AXI_WDATA[SAMPLE_W-1:0]),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_addr_raw,
                             rd_addr_raw, s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA};

endmodule
`default_nettype wire

// File: tb/tb_audio_axi_sample_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_axi_sample_regs
// Description : Self-checking bench for audio_axi_sample_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_axi_sample_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = -1;
    int exp_period = 4;
    int nsamples = 0;

    logic [31:0] rd_exp[$];
    logic [15:0] smp_exp[$];

    typedef struct {
        bit          is_write;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    audio_axi_sample_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    audio_axi_sample_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample stream scoreboard
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (smp_exp.size() == 0) begin
                check("unexpected_sample", {16'h0, sample_out}, 32'hFFFF_FFFF);
            end else begin
                check("sample_value", {16'h0, sample_out}, {16'h0, smp_exp.pop_front()});
                if (last_cyc >= 0) check("sample_period", 32'(cyc - last_cyc), 32'(exp_period));
                last_cyc = cyc;
            end
            nsamples++;
        end
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.S_AXI_AWREADY && n < 50);
        check("aw_accept", {31'h0, bus.S_AXI_AWREADY}, 32'h1);
        check("w_with_aw", {31'h0, bus.S_AXI_WREADY}, 32'h1);
        step();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 50) begin step(); n++; end
        check("bvalid", {31'h0, bus.S_AXI_BVALID}, 32'h1);
        check("bresp", {30'h0, bus.S_AXI_BRESP}, 32'h0);
        step();
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        int n;
        rd_exp.push_back(exp);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.S_AXI_ARREADY && n < 50);
        check("ar_accept", {31'h0, bus.S_AXI_ARREADY}, 32'h1);
        step();
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 50) begin step(); n++; end
        check("rvalid", {31'h0, bus.S_AXI_RVALID}, 32'h1);
        check("rresp", {30'h0, bus.S_AXI_RRESP}, 32'h0);
        check($sformatf("rdata_%h", a), bus.S_AXI_RDATA, rd_exp.pop_front());
        step();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h0001_0000};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h0000_08DB};
        vecs[4]  = '{1'b1, 4'hC, 32'h0000_ABCD, 4'h1, 32'h0};
        vecs[5]  = '{1'b0, 4'hD, 32'h0,        4'h0, 32'h0000_08CD};
        vecs[6]  = '{1'b1, 4'hC, 32'hFFFF_1234, 4'h2, 32'h0};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h0000_12CD};
        vecs[8]  = '{1'b1, 4'h0, 32'hFFFF_FFFC, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000_0000};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0001, 4'hE, 32'h0};
        vecs[11] = '{1'b0, 4'h3, 32'h0,        4'h0, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_awready", {31'h0, bus.S_AXI_AWREADY}, 32'h0);
        check("rst_bvalid",  {31'h0, bus.S_AXI_BVALID},  32'h0);
        check("rst_rvalid",  {31'h0, bus.S_AXI_RVALID},  32'h0);
        check("rst_rdata",   bus.S_AXI_RDATA,            32'h0);
        check("rst_sample",  {15'h0, sample_valid, sample_out}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else                  axi_read(vecs[i].addr, vecs[i].exp);
        end

        // Playback at DIV=3: one sample every 4 cycles, then underrun.
        axi_write(4'hC, 32'h3, 4'hF);
        axi_write(4'h8, 32'h1111, 4'hF); smp_exp.push_back(16'h1111);
        axi_write(4'h8, 32'h2222, 4'hF); smp_exp.push_back(16'h2222);
        axi_write(4'h8, 32'h3333, 4'h0); smp_exp.push_back(16'h3333);
        base = nsamples; exp_period = 4; last_cyc = -1;
        axi_write(4'h0, 32'h1, 4'h1);
        n = 0;
        while (smp_exp.size() != 0 && n < 200) begin step(); n++; end
        check("drain_empty", 32'(smp_exp.size()), 32'h0);
        repeat (10) step();
        check("drain_count", 32'(nsamples - base), 32'd3);
        axi_read(4'h4, 32'h0005_0000);
        axi_write(4'h0, 32'h0, 4'h1);
        axi_write(4'h4, 32'h0004_0000, 4'h4);
        axi_read(4'h4, 32'h0001_0000);

        // Overflow with playback stopped
        for (int v = 1; v <= 17; v++) axi_write(4'h8, 32'(v), 4'h3);
        axi_read(4'h4, 32'h000A_0010);
        axi_write(4'h4, 32'h0008_0000, 4'hB);
        axi_read(4'h4, 32'h000A_0010);
        axi_write(4'h4, 32'h0008_0000, 4'h4);
        axi_read(4'h4, 32'h0002_0010);
        axi_read(4'h8, 32'h0000_0011);
        axi_write(4'h0, 32'h2, 4'h1);
        axi_read(4'h4, 32'h0001_0000);
        for (int v = 0; v < 5; v++) axi_write(4'h8, 32'h100 + 32'(v), 4'hF);
        axi_read(4'h4, 32'h0000_0005);
        axi_write(4'h0, 32'h2, 4'h1);
        axi_read(4'h4, 32'h0001_0000);
        axi_read(4'h0, 32'h0);

        // AW three cycles ahead of W, B held off for five cycles
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'h5; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("aw_alone_wait", {30'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h0);
        end
        bus.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.S_AXI_AWREADY && n < 20);
        check("late_w_accept", {31'h0, bus.S_AXI_AWREADY}, 32'h1);
        step();
        bus.S_AXI_WDATA = 32'h7;
        for (int i = 0; i < 5; i++) begin
            check("b_held", {30'h0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 32'h2);
            step();
        end
        axi_read(4'hC, 32'h5);
        check("b_still_held", {30'h0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 32'h2);
        bus.S_AXI_BREADY = 1'b1;
        step();
        bus.S_AXI_BREADY = 1'b0;
        check("b_done", {31'h0, bus.S_AXI_BVALID}, 32'h0);
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin step(); n++; end
        check("second_accept", {31'h0, bus.S_AXI_AWREADY}, 32'h1);
        step();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin step(); n++; end
        check("second_b", {31'h0, bus.S_AXI_BVALID}, 32'h1);
        step();
        bus.S_AXI_BREADY = 1'b0;
        axi_read(4'hC, 32'h7);

        // Reset in the middle of playback with a read response outstanding
        axi_write(4'hC, 32'h3, 4'hF);
        for (int v = 0; v < 6; v++) begin
            axi_write(4'h8, 32'hA0 + 32'(v), 4'hF);
            smp_exp.push_back(16'hA0 + 16'(v));
        end
        base = nsamples; last_cyc = -1;
        axi_write(4'h0, 32'h1, 4'h1);
        bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.S_AXI_ARREADY && n < 20);
        step();
        bus.S_AXI_ARVALID = 1'b0;
        check("pending_rvalid", {31'h0, bus.S_AXI_RVALID}, 32'h1);
        n = 0;
        while (nsamples == base && n < 50) begin step(); n++; end
        check("playing_before_reset", {31'h0, sample_out == 16'h0}, 32'h0);
        rst_n = 1'b0;
        step();
        check("rst_mid_rvalid", {31'h0, bus.S_AXI_RVALID}, 32'h0);
        check("rst_mid_sample", {15'h0, sample_valid, sample_out}, 32'h0);
        smp_exp.delete();
        rst_n = 1'b1;
        axi_read(4'hC, 32'h0000_08DB);
        axi_read(4'h4, 32'h0001_0000);
        axi_read(4'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
